// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_serializer : 8N1 UART transmit serializer (start, 8 data LSB first, stop)
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 100,
   parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
   input  logic       clk,
   input  logic       nRst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_serial,
   output logic       tx_busy,
   output logic       tx_done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             serial_q, serial_d;
   logic             done_q, done_d;
   logic             bit_end;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      done_d   = 1'b0;
      serial_d = 1'b1;
      bit_end  = (cnt_q == CNT_LAST);

      if (state_q != ST_IDLE) begin
         cnt_d = bit_end ? '0 : cnt_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (tx_valid) begin
               shift_d = tx_data;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_d = ST_DATA;
               idx_d   = 3'd0;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               if (idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Line level is decoded from the next state so the flop shows it on entry.
      case (state_d)
         ST_START: serial_d = 1'b0;
         ST_DATA:  serial_d = shift_d[idx_d];
         default:  serial_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         idx_q    <= 3'd0;
         shift_q  <= 8'd0;
         serial_q <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         serial_q <= serial_d;
         done_q   <= done_d;
      end
   end

   assign tx_serial = serial_q;
   assign tx_busy   = (state_q != ST_IDLE);
   assign tx_ready  = ~tx_busy;
   assign tx_done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_tx_serializer : self-checking bench for uart_tx_serializer (N=4, 2, 1023)
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_uart_tx_serializer;

   logic clk = 1'b0;
   logic nRst;
   always #5 clk = ~clk;

   logic [7:0] d4, d2, dx;
   logic       v4, v2, vx;
   logic       r4, r2, rx, s4, s2, sx, b4, b2, bx, o4, o2, ox;

   uart_tx_serializer #(.CLKS_PER_BIT(4)) u_dut4 (
      .clk(clk), .nRst(nRst), .tx_data(d4), .tx_valid(v4),
      .tx_ready(r4), .tx_serial(s4), .tx_busy(b4), .tx_done(o4));
   uart_tx_serializer #(.CLKS_PER_BIT(2)) u_dut2 (
      .clk(clk), .nRst(nRst), .tx_data(d2), .tx_valid(v2),
      .tx_ready(r2), .tx_serial(s2), .tx_busy(b2), .tx_done(o2));
   uart_tx_serializer #(.CLKS_PER_BIT(1023)) u_dutx (
      .clk(clk), .nRst(nRst), .tx_data(dx), .tx_valid(vx),
      .tx_ready(rx), .tx_serial(sx), .tx_busy(bx), .tx_done(ox));

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;   // bit i = line level of frame bit slot i
   } vec_t;

   vec_t tbl [7];

   function automatic int n_of(int sel);
      case (sel)
         0:       return 4;
         1:       return 2;
         default: return 1023;
      endcase
   endfunction

   function automatic logic get_ser(int sel);
      case (sel)
         0:       return s4;
         1:       return s2;
         default: return sx;
      endcase
   endfunction

   function automatic logic get_busy(int sel);
      case (sel)
         0:       return b4;
         1:       return b2;
         default: return bx;
      endcase
   endfunction

   function automatic logic get_ready(int sel);
      case (sel)
         0:       return r4;
         1:       return r2;
         default: return rx;
      endcase
   endfunction

   function automatic logic get_done(int sel);
      case (sel)
         0:       return o4;
         1:       return o2;
         default: return ox;
      endcase
   endfunction

   task automatic drive(int sel, logic [7:0] d, logic v);
      case (sel)
         0:       begin d4 = d; v4 = v; end
         1:       begin d2 = d; v2 = v; end
         default: begin dx = d; vx = v; end
      endcase
   endtask

   // Reference model: an 8N1 frame is start(0), data LSB first, stop(1).
   function automatic logic [9:0] frame_of(logic [7:0] d);
      return {1'b1, d, 1'b0};
   endfunction

   function automatic logic line_at(logic [9:0] f, int k, int n);
      if (k < 1 || k > 10 * n) return 1'b1;
      return f[(k - 1) / n];
   endfunction

   task automatic check(string nm, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   // Request a frame and return just after the accept edge.
   task automatic start(int sel, logic [7:0] d, bit hold, string nm);
      int w = 0;
      @(posedge clk);
      #1 drive(sel, d, 1'b1);
      @(negedge clk);
      while (!get_ready(sel) && w < 20000) begin
         @(negedge clk);
         w++;
      end
      check({nm, " ready before accept"}, int'(w < 20000), 1);
      @(posedge clk);
      #1 if (!hold) drive(sel, d, 1'b0);
   endtask

   // Compare cycles 1..10N+1 after the accept edge against the model.
   task automatic check_frame(int sel, logic [9:0] f, string nm);
      int n = n_of(sel);
      int bad_ser = -1, bad_busy = -1, bad_rdy = -1, bad_done = -1;
      for (int k = 1; k <= 10 * n + 1; k++) begin
         @(negedge clk);
         if (get_ser(sel) !== line_at(f, k, n) && bad_ser < 0) bad_ser = k;
         if (get_busy(sel) !== (k <= 10 * n) && bad_busy < 0) bad_busy = k;
         if (get_ready(sel) !== (k > 10 * n) && bad_rdy < 0) bad_rdy = k;
         if (get_done(sel) !== (k == 10 * n + 1) && bad_done < 0) bad_done = k;
      end
      check({nm, " serial first bad cycle"}, bad_ser, -1);
      check({nm, " busy first bad cycle"}, bad_busy, -1);
      check({nm, " ready first bad cycle"}, bad_rdy, -1);
      check({nm, " done first bad cycle"}, bad_done, -1);
   endtask

   task automatic send(int sel, logic [7:0] d, logic [9:0] f, string nm);
      start(sel, d, 1'b0, nm);
      check_frame(sel, f, nm);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      logic [7:0] rd;

      tbl[0] = '{8'hA5, 10'b1101001010};
      tbl[1] = '{8'h00, 10'b1000000000};
      tbl[2] = '{8'hFF, 10'b1111111110};
      tbl[3] = '{8'h01, 10'b1000000010};
      tbl[4] = '{8'h5A, 10'b1010110100};
      tbl[5] = '{8'h81, 10'b1100000010};
      tbl[6] = '{8'h3C, 10'b1001111000};

      nRst = 1'b0;
      d4 = '0; d2 = '0; dx = '0;
      v4 = 1'b0; v2 = 1'b0; vx = 1'b0;

      // Reset state, during and after reset
      repeat (3) @(negedge clk);
      check("rst serial", int'(s4), 1);
      check("rst ready", int'(r4), 1);
      check("rst busy", int'(b4), 0);
      check("rst done", int'(o4), 0);
      @(posedge clk);
      #2 nRst = 1'b1;
      @(negedge clk);
      check("post-rst serial", int'(s4), 1);
      check("post-rst ready", int'(r4), 1);
      check("post-rst busy", int'(b4), 0);
      check("post-rst done", int'(o4), 0);

      // Table-driven frames
      for (int i = 0; i < 7; i++) begin
         send(0, tbl[i].data, tbl[i].frame, $sformatf("tbl%0d", i));
      end

      // Requests and data changes while busy are ignored
      start(0, 8'hA5, 1'b0, "ignore");
      fork
         check_frame(0, tbl[0].frame, "ignore");
         begin
            repeat (9) @(posedge clk);
            #1 drive(0, 8'h3C, 1'b1);
            @(posedge clk);
            #1 drive(0, 8'h3C, 1'b0);
            repeat (10) @(posedge clk);
            #1 d4 = 8'h77;
         end
      join
      bad = 0;
      repeat (16) begin
         @(negedge clk);
         if (b4 !== 1'b0 || s4 !== 1'b1) bad++;
      end
      check("ignore no second frame", bad, 0);

      // Back-to-back with tx_valid held high
      start(0, 8'h00, 1'b1, "b2b1");
      fork
         check_frame(0, tbl[1].frame, "b2b1");
         begin
            repeat (5) @(posedge clk);
            #1 d4 = 8'hFF;
         end
      join
      fork
         check_frame(0, tbl[2].frame, "b2b2");
         begin
            @(posedge clk);
            #1 v4 = 1'b0;
         end
      join

      // Reset in the middle of a frame
      start(0, 8'h5A, 1'b0, "rstmid");
      repeat (16) @(posedge clk);
      #2 nRst = 1'b0;
      #1;
      check("rstmid serial async", int'(s4), 1);
      check("rstmid busy async", int'(b4), 0);
      check("rstmid done async", int'(o4), 0);
      repeat (2) @(negedge clk);
      check("rstmid done in reset", int'(o4), 0);
      @(posedge clk);
      #3 nRst = 1'b1;
      bad = 0;
      repeat (12) begin
         @(negedge clk);
         if (o4 !== 1'b0 || s4 !== 1'b1 || b4 !== 1'b0) bad++;
      end
      check("rstmid quiet after release", bad, 0);
      send(0, 8'h81, tbl[5].frame, "rstmid new");

      // Randomised frames against the model
      for (int i = 0; i < 6; i++) begin
         rd = 8'($urandom);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         send(0, rd, frame_of(rd), $sformatf("rand4_%0d", i));
      end
      for (int i = 0; i < 3; i++) begin
         rd = 8'($urandom);
         send(1, rd, frame_of(rd), $sformatf("rand2_%0d", i));
      end

      // Timing extremes
      send(1, 8'h01, tbl[3].frame, "n2");
      send(2, 8'h01, tbl[3].frame, "n1023");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit end of the board-to-board serial link: serializes one 8-bit byte into an 8N1 frame (start bit, 8 data bits LSB first, 1 stop bit) on tx_serial.
- Bit timing comes from an internal per-bit cycle counter with clear-on-bit-boundary semantics, consistent with the team's divider blocks.
- Sits between the game-logic message source (guess letters, status bytes) and the wireless module's UART input; pairs with the existing receive-side timing.

Parameters:
- CLKS_PER_BIT, 100, clock cycles per serial bit; legal range 2..1023.
- CNT_W, $clog2(CLKS_PER_BIT), width of the internal bit-timing counter (derived; do not override).

Ports:
- clk  input  1  system clock, rising-edge active
- nRst  input  1  asynchronous active-low reset
- tx_data  input  8  byte to send; sampled only on the accept edge
- tx_valid  input  1  request to send tx_data; level, sampled each rising edge
- tx_ready  output  1  high when a request will be accepted this cycle (IDLE only)
- tx_serial  output  1  serial line, registered; idles high
- tx_busy  output  1  high from the cycle after accept until the frame completes
- tx_done  output  1  one-cycle pulse marking frame completion

Behaviour:
- One clock (clk); reset is asynchronous and active-low (nRst). All state is in one clocked process.
- Reset values:
  - state = IDLE, bit counter = 0, bit index = 0, shift register = 0.
  - tx_serial = 1, tx_ready = 1, tx_busy = 0, tx_done = 0.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - tx_ready = 1 and tx_serial = 1.
  - A rising edge with tx_valid = 1 is the accept edge: latch tx_data into the shift register, clear the bit counter, go to START.
- START: tx_serial = 0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx_serial = shift register bit [bit index], LSB first, each bit held exactly CLKS_PER_BIT cycles.
  - After bit index 7 completes, go to STOP.
- STOP: tx_serial = 1 for exactly CLKS_PER_BIT cycles, then go to IDLE.
- tx_done is high only in the first IDLE cycle after STOP.
- Bit timing:
  - The counter counts 0..CLKS_PER_BIT-1. The bit ends on the cycle where counter == CLKS_PER_BIT-1.
  - On that cycle the counter wraps to 0 and the state or bit index advances.
  - The counter is cleared on every state entry.
- Latency:
  - tx_serial first goes low in the cycle immediately after the accept edge.
  - The frame occupies exactly 10*CLKS_PER_BIT cycles.
  - tx_done is asserted in cycle 10*CLKS_PER_BIT+1 after the accept edge.
- tx_busy is high for exactly 10*CLKS_PER_BIT cycles; tx_ready = ~tx_busy.
- Boundary conditions:
  - tx_valid while busy: ignored and not queued. The requester must hold or re-assert it.
  - tx_data changes during a frame: no effect; the frame uses the latched byte only.
  - Back-to-back: tx_valid held high through the tx_done cycle is accepted on that edge. This gives exactly one idle-high cycle between the stop bit and the next start bit.
  - tx_valid held continuously high: frames repeat with that one-cycle gap, and each frame latches the tx_data present at its own accept edge.
  - Reset mid-frame:
    - Immediate abort; tx_serial returns high asynchronously.
    - No tx_done pulse is generated.
    - After reset release, the first edge with tx_valid = 1 starts a fresh frame.
- tx_serial has no glitches: it is a flop output, never combinational from the state.

Test Plan:
- Reset check: CLKS_PER_BIT=4, hold nRst low 3 cycles -> tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0 during and after reset.
- Single frame: tx_data=8'hA5, tx_valid pulsed 1 cycle -> tx_serial sequence in 4-cycle bits is 0,1,0,1,0,0,1,0,1,1. tx_busy is high 40 cycles and tx_done pulses once at cycle 41.
- Ignore while busy: during the 0xA5 frame, pulse tx_valid with tx_data=8'h3C at cycle 10 and change tx_data at cycle 20 -> the waveform is unchanged and no second frame follows.
- Back-to-back: tx_valid held high with tx_data=8'h00, then 8'hFF at the second accept -> frame 1 data bits are all 0. Exactly one high cycle separates stop from the next start, and frame 2 data bits are all 1.
- Reset mid-frame: assert nRst low at cycle 17 of a 0x5A frame -> tx_serial=1 immediately with no tx_done. After release, a new 0x81 request produces a complete, correct frame.
- Timing extreme: CLKS_PER_BIT=2 and CLKS_PER_BIT=1023, send 8'h01 -> each bit lasts exactly 2 (resp. 1023) cycles and the total frame is 20 (resp. 10230) cycles.
